// File: rtl/instruction_fetch_controller.sv
// Two-byte instruction fetch sequencer: owns the PC, drives the 8-bit memory read,
// and steers bytes into the 16-bit IR low byte first, with a per-byte wait timeout.
module instruction_fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_load_value,
  input  logic        i_mem_ready,
  output logic        o_mem_read,
  output logic [15:0] o_address,
  output logic        o_ir_write,
  output logic        o_ir_lh,
  output logic [15:0] o_pc,
  output logic        o_busy,
  output logic        o_fetch_done,
  output logic        o_fault
);

  typedef enum logic [1:0] {StIdle, StFetchLo, StFetchHi, StDone} state_e;

  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MAX_WAIT - 1);

  state_e            r_state;
  logic [15:0]       r_pc;
  logic [15:0]       r_start_pc;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;

  logic w_fetching;
  logic w_timeout;

  assign w_fetching = (r_state == StFetchLo) || (r_state == StFetchHi);
  assign w_timeout  = w_fetching && !i_mem_ready && (r_wait == WaitLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_start_pc <= RESET_PC;
      r_wait     <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (i_pc_load) begin
        // A branch/jump flushes any fetch in flight and suppresses Start.
        r_pc    <= i_pc_load_value;
        r_state <= StIdle;
        r_wait  <= '0;
      end else begin
        case (r_state)
          StIdle, StDone: begin
            if (i_start) begin
              r_start_pc <= r_pc;
              r_wait     <= '0;
              r_state    <= StFetchLo;
            end else begin
              r_state <= StIdle;
            end
          end
          StFetchLo, StFetchHi: begin
            if (i_mem_ready) begin
              r_pc    <= r_pc + 16'd1;
              r_wait  <= '0;
              r_state <= (r_state == StFetchLo) ? StFetchHi : StDone;
            end else if (w_timeout) begin
              // Rewind to the instruction start so a failed high byte undoes the low-byte step.
              r_fault <= 1'b1;
              r_pc    <= r_start_pc;
              r_wait  <= '0;
              r_state <= StIdle;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_mem_read   = w_fetching;
  assign o_address    = r_pc;
  assign o_pc         = r_pc;
  assign o_busy       = w_fetching;
  assign o_ir_lh      = (r_state == StFetchHi);
  assign o_ir_write   = w_fetching && i_mem_ready && !i_pc_load;
  assign o_fetch_done = (r_state == StDone);
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a small IR model fed by a byte bus.
module tb_instruction_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        mem_ready;
  logic        mem_read;
  logic [15:0] address;
  logic        ir_write;
  logic        ir_lh;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fault;

  logic [7:0]  bus;
  logic [15:0] ir;

  int n_checks;
  int n_fail;

  instruction_fetch_controller #(
    .RESET_PC(16'h0000),
    .MAX_WAIT(8),
    .WAIT_W  (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_pc_load      (pc_load),
    .i_pc_load_value(pc_load_value),
    .i_mem_ready    (mem_ready),
    .o_mem_read     (mem_read),
    .o_address      (address),
    .o_ir_write     (ir_write),
    .o_ir_lh        (ir_lh),
    .o_pc           (pc),
    .o_busy         (busy),
    .o_fetch_done   (fetch_done),
    .o_fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register model written by the DUT's byte strobes.
  always @(posedge clk) begin
    if (ir_write) begin
      if (ir_lh) ir[15:8] <= bus;
      else       ir[7:0]  <= bus;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    ir            = 16'h0000;
    bus           = 8'h00;
    rst_n         = 1'b0;
    start         = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 16'h0000;
    mem_ready     = 1'b0;

    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", address, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_memread", {15'd0, mem_read}, 16'd0);
    chk("rst_done", {15'd0, fetch_done}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait fetch of 0x1234 from PC 0.
    start = 1'b1; mem_ready = 1'b1; bus = 8'h34;
    tick();
    start = 1'b0; #1;
    chk("t1_busy_lo", {15'd0, busy}, 16'd1);
    chk("t1_memread_lo", {15'd0, mem_read}, 16'd1);
    chk("t1_lh_lo", {15'd0, ir_lh}, 16'd0);
    chk("t1_irw_lo", {15'd0, ir_write}, 16'd1);
    chk("t1_addr_lo", address, 16'h0000);
    tick();
    bus = 8'h12; #1;
    chk("t1_lh_hi", {15'd0, ir_lh}, 16'd1);
    chk("t1_irw_hi", {15'd0, ir_write}, 16'd1);
    chk("t1_addr_hi", address, 16'h0001);
    tick();
    chk("t1_done", {15'd0, fetch_done}, 16'd1);
    chk("t1_busy_done", {15'd0, busy}, 16'd0);
    chk("t1_irw_done", {15'd0, ir_write}, 16'd0);
    chk("t1_ir", ir, 16'h1234);
    chk("t1_pc", pc, 16'h0002);
    tick();
    chk("t1_done_pulse", {15'd0, fetch_done}, 16'd0);
    chk("t1_busy_after", {15'd0, busy}, 16'd0);

    // Wait states: 3 low cycles on the low byte, 2 on the high byte.
    pc_load = 1'b1; pc_load_value = 16'h0000;
    tick();
    pc_load = 1'b0;
    chk("t2_pc_load", pc, 16'h0000);
    start = 1'b1; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_memread_lo", {15'd0, mem_read}, 16'd1);
      chk("t2_addr_lo", address, 16'h0000);
      chk("t2_irw_wait", {15'd0, ir_write}, 16'd0);
      tick();
    end
    mem_ready = 1'b1; bus = 8'hCD;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_memread_hi", {15'd0, mem_read}, 16'd1);
      chk("t2_addr_hi", address, 16'h0001);
      chk("t2_fault_wait", {15'd0, fault}, 16'd0);
      tick();
    end
    mem_ready = 1'b1; bus = 8'hAB;
    tick();
    chk("t2_done", {15'd0, fetch_done}, 16'd1);
    chk("t2_fault", {15'd0, fault}, 16'd0);
    chk("t2_ir", ir, 16'hABCD);
    chk("t2_pc", pc, 16'h0002);
    tick();

    // Timeout on the high byte starting at PC 0x0010.
    pc_load = 1'b1; pc_load_value = 16'h0010;
    tick();
    pc_load = 1'b0;
    start = 1'b1; mem_ready = 1'b1; bus = 8'h55;
    tick();
    start = 1'b0;
    tick();
    mem_ready = 1'b0;
    chk("t3_pc_mid", pc, 16'h0011);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_busy_wait", {15'd0, busy}, 16'd1);
      chk("t3_no_fault", {15'd0, fault}, 16'd0);
    end
    tick();
    chk("t3_fault", {15'd0, fault}, 16'd1);
    chk("t3_pc_restore", pc, 16'h0010);
    chk("t3_idle", {15'd0, busy}, 16'd0);
    chk("t3_no_done", {15'd0, fetch_done}, 16'd0);
    tick();
    chk("t3_fault_pulse", {15'd0, fault}, 16'd0);

    // PC wrap from 0xFFFF.
    pc_load = 1'b1; pc_load_value = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    chk("t4_pc_load", pc, 16'hFFFF);
    start = 1'b1; mem_ready = 1'b1; bus = 8'h78;
    tick();
    start = 1'b0; #1;
    chk("t4_addr_lo", address, 16'hFFFF);
    tick();
    bus = 8'h9A;
    chk("t4_addr_wrap", address, 16'h0000);
    tick();
    chk("t4_pc", pc, 16'h0001);
    chk("t4_ir", ir, 16'h9A78);
    tick();

    // PCLoad during FETCH_HI with MemReady high flushes the fetch.
    start = 1'b1; mem_ready = 1'b1; bus = 8'h11;
    tick();
    start = 1'b0;
    tick();
    pc_load = 1'b1; pc_load_value = 16'h0200; bus = 8'hEE; #1;
    chk("t5_irw_forced", {15'd0, ir_write}, 16'd0);
    tick();
    pc_load = 1'b0;
    chk("t5_pc", pc, 16'h0200);
    chk("t5_idle", {15'd0, busy}, 16'd0);
    chk("t5_no_done", {15'd0, fetch_done}, 16'd0);
    chk("t5_no_fault", {15'd0, fault}, 16'd0);
    chk("t5_ir_kept", ir, 16'h9A11);
    start = 1'b1; bus = 8'h22;
    tick();
    start = 1'b0; #1;
    chk("t5_addr_lo", address, 16'h0200);
    tick();
    bus = 8'h33;
    chk("t5_addr_hi", address, 16'h0201);
    tick();
    chk("t5_done", {15'd0, fetch_done}, 16'd1);
    chk("t5_ir", ir, 16'h3322);
    chk("t5_pc_end", pc, 16'h0202);
    tick();

    // Back-to-back fetches with Start held high.
    pc_load = 1'b1; pc_load_value = 16'h0000;
    tick();
    pc_load = 1'b0;
    start = 1'b1; mem_ready = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t6_not_done", {15'd0, fetch_done}, 16'd0);
      tick();
      chk("t6_done", {15'd0, fetch_done}, 16'd1);
      chk("t6_pc", pc, 16'(2 * k));
      tick();
      chk("t6_refetch", {15'd0, busy}, 16'd1);
    end
    tick();
    chk("t6_pc_mid", pc, 16'h0007);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pc", pc, 16'h0000);
    chk("t6_rst_addr", address, 16'h0000);
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_memread", {15'd0, mem_read}, 16'd0);
    chk("t6_rst_irw", {15'd0, ir_write}, 16'd0);
    chk("t6_rst_lh", {15'd0, ir_lh}, 16'd0);
    chk("t6_rst_done", {15'd0, fetch_done}, 16'd0);
    chk("t6_rst_fault", {15'd0, fault}, 16'd0);
    start = 1'b0; mem_ready = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    chk("t6_idle_after", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
